addr_gen_pipe: RTL and testbench
================================

Name: addr_gen_pipe

Overview:
Parametrised, pipelined effective-address generator for the datapath.
- Selects a base (next PC or register operand) and a sign-extended IR offset field (three selectable widths, or zero).
- Optionally scales the offset, adds it to the base, and registers the result.
- Two-stage valid/ready pipeline with carry and signed-overflow flags, so it can sit between decode and the MAR/PC-load logic under back-pressure.

Parameters:
WIDTH, 16, datapath/address width in bits.
OFF_A, 6, width of short offset field IR[OFF_A-1:0].
OFF_B, 9, width of medium offset field IR[OFF_B-1:0].
OFF_C, 11, width of long offset field IR[OFF_C-1:0]; must satisfy OFF_A < OFF_B < OFF_C <= WIDTH.

Ports:
Clk  in  1  clock, all state on rising edge.
Reset_n  in  1  asynchronous, active-low reset.
in_valid  in  1  request present on inputs.
in_ready  out  1  block accepts request this cycle.
addr1_sel  in  1  0 = base_pc, 1 = base_reg.
addr2_sel  in  2  00 = zero, 01 = sext OFF_A, 10 = sext OFF_B, 11 = sext OFF_C.
scale  in  1  1 = offset shifted left by 1 after extension.
base_pc  in  WIDTH  incremented PC.
base_reg  in  WIDTH  register-file operand.
ir  in  WIDTH  instruction register.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
ea  out  WIDTH  effective address.
carry  out  1  unsigned carry-out of the add (wrap-around).
ovf  out  1  signed two's-complement overflow of the add.

Behaviour:
- Reset (Reset_n low, async): both stage valids cleared; out_valid=0, ea=0, carry=0, ovf=0; stage-1 operand registers cleared. Any in-flight transaction is discarded, with no partial output. Exit from reset is synchronous to Clk.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - Inputs are sampled only on an accepted transfer.
  - ea/carry/ovf are held stable while out_valid && !out_ready.
- Stage 1 (S1):
  - On accept, register op1 = addr1_sel ? base_reg : base_pc.
  - Register op2 = selected field sign-extended to WIDTH (zero if 00), then shifted left 1 if scale. The bit shifted out of the MSB is dropped.
  - Set s1_v=1.
- Stage 2 (S2):
  - When S1 advances, register ea = op1+op2 mod 2^WIDTH.
  - carry = bit WIDTH of the (WIDTH+1)-bit unsigned sum.
  - ovf = (op1[MSB]==op2[MSB]) && (ea[MSB]!=op1[MSB]).
  - out_valid=s2_v.
- Advance rules (combinational):
  - s2_adv = !s2_v || out_ready.
  - s1_adv = s1_v && s2_adv.
  - in_ready = !s1_v || s2_adv (in_ready must not depend on in_valid).
- Latency: 2 cycles from accept to out_valid with no back-pressure; throughput 1 per cycle.
- Simultaneous events:
  - Accept into S1 in the same cycle S1 advances to S2: both occur.
  - Output drained in the same cycle S2 refills: new result is loaded, out_valid stays 1.
  - S1 advances with no new accept: s1_v cleared.
  - S2 drained with no S1 advance: s2_v cleared.
- Full: with both stages valid and out_ready=0, in_ready=0 and no state changes. Capacity is exactly 2 transactions; none are dropped or duplicated.
- Empty: out_valid=0; ea/carry/ovf retain their last values.
- addr2_sel=00 yields ea=op1 and carry=ovf=0, regardless of scale.

Test Plan:
1. addr1_sel=0, base_pc=0x3000, addr2_sel=10, ir[8:0]=0x1FF, scale=0, out_ready=1 -> 2 cycles later ea=0x2FFF, carry=1, ovf=0, out_valid for 1 cycle.
2. addr1_sel=1, base_reg=0x4000, addr2_sel=01, ir[5:0]=0x05, scale=1 -> ea=0x400A, carry=0, ovf=0; repeat with ir[5:0]=0x20 -> ea=0x3FC0.
3. Wrap and overflow:
   - base_reg=0xFFFF, addr2_sel=01, ir[5:0]=0x01 -> ea=0x0000, carry=1, ovf=0.
   - base_reg=0x7FFF, same offset -> ea=0x8000, carry=0, ovf=1.
   - addr2_sel=00 -> ea=base, flags 0.
4. Back-pressure: issue 4 back-to-back requests (ea 0x0001..0x0004) with out_ready=0 -> first two accepted, in_ready=0 from the third cycle, ea=0x0001 held. Raise out_ready -> results emerge in order 1,2,3,4, one per cycle, none lost.
5. Reset mid-operation: two requests in flight, assert Reset_n=0 asynchronously mid-cycle -> out_valid, ea, carry, ovf go to 0 immediately. After release, in_ready=1 and the next request gives the correct result at 2-cycle latency.
6. Parameter build WIDTH=32, OFF_C=21: base_pc=0x0001_0000, addr2_sel=11, ir[20:0]=0x1FFFFF -> ea=0x0000_FFFF, carry=1.

Source files
------------

// File: rtl/addr_gen_pipe.sv
// addr_gen_pipe: two-stage valid/ready effective-address generator.
// Stage 1 registers the selected base and the extended/scaled offset;
// stage 2 registers their sum together with carry and signed-overflow flags.
module addr_gen_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OFF_A = 6,
  parameter int unsigned OFF_B = 9,
  parameter int unsigned OFF_C = 11
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             addr1_sel,
  input  logic [1:0]       addr2_sel,
  input  logic             scale,
  input  logic [WIDTH-1:0] base_pc,
  input  logic [WIDTH-1:0] base_reg,
  input  logic [WIDTH-1:0] ir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ea,
  output logic             carry,
  output logic             ovf
);

  localparam int unsigned MSB = WIDTH - 1;

  // offset field selector encodings
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_A    = 2'b01;
  localparam logic [1:0] SEL_B    = 2'b10;
  localparam logic [1:0] SEL_C    = 2'b11;

  // pipeline state
  logic             r_s1_v;
  logic             r_s2_v;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;
  logic [WIDTH-1:0] r_ea;
  logic             r_carry;
  logic             r_ovf;

  // handshake and datapath nets
  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_accept;
  logic             w_drain;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_sext_a;
  logic [WIDTH-1:0] w_sext_b;
  logic [WIDTH-1:0] w_sext_c;
  logic [WIDTH-1:0] w_off;
  logic [WIDTH-1:0] w_op2;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;

  // Upper IR bits beyond the long field never feed the datapath.
  if (OFF_C < WIDTH) begin : g_ir_hi
    logic unused_ir_hi;
    assign unused_ir_hi = ^ir[WIDTH-1:OFF_C];
  end

  // Stage advance rules; in_ready deliberately ignores in_valid.
  assign w_s2_adv = !r_s2_v || out_ready;
  assign w_s1_adv = r_s1_v && w_s2_adv;
  assign in_ready = !r_s1_v || w_s2_adv;
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_s2_v && out_ready;

  // Base operand select.
  assign w_op1 = addr1_sel ? base_reg : base_pc;

  // Sign-extend each IR offset field to the full datapath width.
  always_comb begin
    w_sext_a              = {WIDTH{ir[OFF_A-1]}};
    w_sext_a[OFF_A-1:0]   = ir[OFF_A-1:0];
    w_sext_b              = {WIDTH{ir[OFF_B-1]}};
    w_sext_b[OFF_B-1:0]   = ir[OFF_B-1:0];
    w_sext_c              = {WIDTH{ir[OFF_C-1]}};
    w_sext_c[OFF_C-1:0]   = ir[OFF_C-1:0];
  end

  // Offset field select; zero selection is unaffected by scaling.
  always_comb begin
    w_off = '0;
    unique case (addr2_sel)
      SEL_ZERO: w_off = '0;
      SEL_A:    w_off = w_sext_a;
      SEL_B:    w_off = w_sext_b;
      SEL_C:    w_off = w_sext_c;
      default:  w_off = '0;
    endcase
  end

  // Optional x2 scale; the bit shifted out of the MSB is dropped.
  assign w_op2 = scale ? {w_off[MSB-1:0], 1'b0} : w_off;

  // Full-width sum plus carry, and signed overflow of the registered operands.
  assign w_sum = {1'b0, r_op1} + {1'b0, r_op2};
  assign w_ovf = (r_op1[MSB] == r_op2[MSB]) && (w_sum[MSB] != r_op1[MSB]);

  // Stage 1: capture operands on accept, empty when handed on with no refill.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_v <= 1'b0;
      r_op1  <= '0;
      r_op2  <= '0;
    end else if (w_accept) begin
      r_s1_v <= 1'b1;
      r_op1  <= w_op1;
      r_op2  <= w_op2;
    end else if (w_s1_adv) begin
      r_s1_v <= 1'b0;
    end
  end

  // Stage 2: load result when stage 1 advances, empty on drain with no refill.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s2_v  <= 1'b0;
      r_ea    <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_v  <= 1'b1;
      r_ea    <= w_sum[MSB:0];
      r_carry <= w_sum[WIDTH];
      r_ovf   <= w_ovf;
    end else if (w_drain) begin
      r_s2_v  <= 1'b0;
    end
  end

  // Registered outputs; result fields persist while the pipe is empty.
  assign out_valid = r_s2_v;
  assign ea        = r_ea;
  assign carry     = r_carry;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_addr_gen_pipe.sv
// Self-checking bench for addr_gen_pipe: directed cases, back-pressure,
// mid-cycle reset, randomized scoreboard run and a 32-bit build.
module tb_addr_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 16-bit instance signals
  logic        in_valid, in_ready, a1, sc, out_valid, out_ready, carry, ovf;
  logic [1:0]  a2;
  logic [15:0] pc, rg, ir, ea;

  // 32-bit instance signals
  logic        w_in_valid, w_in_ready, w_a1, w_sc, w_out_valid, w_out_ready, w_carry, w_ovf;
  logic [1:0]  w_a2;
  logic [31:0] w_pc, w_rg, w_ir, w_ea;

  int checks   = 0;
  int failures = 0;

  addr_gen_pipe dut (
    .Clk(clk), .Reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .addr1_sel(a1), .addr2_sel(a2), .scale(sc), .base_pc(pc), .base_reg(rg),
    .ir(ir), .out_valid(out_valid), .out_ready(out_ready), .ea(ea),
    .carry(carry), .ovf(ovf)
  );

  addr_gen_pipe #(.WIDTH(32), .OFF_A(6), .OFF_B(9), .OFF_C(21)) dut32 (
    .Clk(clk), .Reset_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .addr1_sel(w_a1), .addr2_sel(w_a2), .scale(w_sc), .base_pc(w_pc), .base_reg(w_rg),
    .ir(w_ir), .out_valid(w_out_valid), .out_ready(w_out_ready), .ea(w_ea),
    .carry(w_carry), .ovf(w_ovf)
  );

  // Reference: signed offset arithmetic on integers, then reduce modulo 2^w.
  function automatic void ref_ea(input int w, input int fw, input bit scl, input longint op1,
                                 input longint irv, output longint ea_o, output bit c_o,
                                 output bit v_o);
    longint m, off, op2, sum, s1, s2, ss;
    m   = longint'(1) << w;
    off = 0;
    if (fw > 0) begin
      off = irv & ((longint'(1) << fw) - 1);
      if (off >= (longint'(1) << (fw - 1))) off = off - (longint'(1) << fw);
    end
    if (scl) off = off * 2;
    op2  = ((off % m) + m) % m;
    sum  = op1 + op2;
    ea_o = sum % m;
    c_o  = (sum >= m);
    s1   = (op1 >= m / 2) ? op1 - m : op1;
    s2   = (op2 >= m / 2) ? op2 - m : op2;
    ss   = s1 + s2;
    v_o  = (ss >= m / 2) || (ss < -(m / 2));
  endfunction

  function automatic int fw16(input logic [1:0] s);
    case (s)
      2'd1:    return 6;
      2'd2:    return 9;
      2'd3:    return 11;
      default: return 0;
    endcase
  endfunction

  function automatic int fw32(input logic [1:0] s);
    case (s)
      2'd1:    return 6;
      2'd2:    return 9;
      2'd3:    return 21;
      default: return 0;
    endcase
  endfunction

  // Expected {ovf, carry, ea} for the request currently on the 16-bit inputs.
  function automatic logic [17:0] model16_now();
    longint e;
    bit c, v;
    ref_ea(16, fw16(a2), bit'(sc), a1 ? longint'(rg) : longint'(pc), longint'(ir), e, c, v);
    return {v, c, 16'(e)};
  endfunction

  task automatic put_req(input logic a1_i, input logic [1:0] a2_i, input logic sc_i,
                         input logic [15:0] pc_i, input logic [15:0] rg_i,
                         input logic [15:0] ir_i);
    a1 = a1_i; a2 = a2_i; sc = sc_i; pc = pc_i; rg = rg_i; ir = ir_i;
  endtask

  // Offer the request on the inputs, then wait (bounded) for its result.
  task automatic send_and_get(output logic [15:0] e, output logic c, output logic v,
                              output int lat, output bit ok);
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    ok = 1'b0;
    for (lat = 1; lat < 10; lat++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    e = ea; c = carry; v = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    put_req(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0);
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_a1 = 1'b0; w_a2 = 2'b00; w_sc = 1'b0;
    w_pc = '0; w_rg = '0; w_ir = '0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || ea !== 16'h0 || carry !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b ea=%h c=%b o=%b, want 0 0000 0 0",
               out_valid, ea, carry, ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] e, exp_e;
    logic c, v, exp_c, exp_v;
    int lat;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin put_req(1'b0, 2'b10, 1'b0, 16'h3000, 16'h0000, 16'h01FF); exp_e = 16'h2FFF; exp_c = 1; exp_v = 0; end
        1: begin put_req(1'b1, 2'b01, 1'b1, 16'h0000, 16'h4000, 16'h0005); exp_e = 16'h400A; exp_c = 0; exp_v = 0; end
        2: begin put_req(1'b1, 2'b01, 1'b1, 16'h0000, 16'h4000, 16'h0020); exp_e = 16'h3FC0; exp_c = 1; exp_v = 0; end
        3: begin put_req(1'b1, 2'b01, 1'b0, 16'h0000, 16'hFFFF, 16'h0001); exp_e = 16'h0000; exp_c = 1; exp_v = 0; end
        4: begin put_req(1'b1, 2'b01, 1'b0, 16'h0000, 16'h7FFF, 16'h0001); exp_e = 16'h8000; exp_c = 0; exp_v = 1; end
        5: begin put_req(1'b1, 2'b00, 1'b1, 16'h0000, 16'h1234, 16'hFFFF); exp_e = 16'h1234; exp_c = 0; exp_v = 0; end
        6: begin put_req(1'b1, 2'b11, 1'b0, 16'h0000, 16'h0100, 16'h0400); exp_e = 16'hFD00; exp_c = 0; exp_v = 0; end
        default: begin put_req(1'b1, 2'b11, 1'b0, 16'h0000, 16'h0100, 16'hF400); exp_e = 16'hFD00; exp_c = 0; exp_v = 0; end
      endcase
      send_and_get(e, c, v, lat, ok);
      checks++;
      if (!ok || e !== exp_e || c !== exp_c || v !== exp_v) begin
        failures++;
        $display("FAIL directed_%0d: got ok=%b ea=%h c=%b o=%b, want ea=%h c=%b o=%b",
                 i, ok, e, c, v, exp_e, exp_c, exp_v);
      end
      checks++;
      if (lat != 2) begin
        failures++;
        $display("FAIL latency_%0d: got %0d want 2", i, lat);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || ea !== exp_e) begin
        failures++;
        $display("FAIL single_pulse_%0d: got v=%b ea=%h, want v=0 ea=%h", i, out_valid, ea, exp_e);
      end
    end
  endtask

  task automatic test_back_pressure();
    int next_req, next_out, cyc0, cycl;
    next_req = 1; next_out = 1; cyc0 = -1; cycl = -1;
    put_req(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0);
    for (int c = 0; c < 30 && next_out <= 4; c++) begin
      @(negedge clk);
      in_valid  = (next_req <= 4);
      pc        = 16'(next_req);
      out_ready = (c >= 5);
      #1;
      if (c >= 2 && c <= 4) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || ea !== 16'h0001) begin
          failures++;
          $display("FAIL bp_stall_c%0d: got rdy=%b v=%b ea=%h, want rdy=0 v=1 ea=0001",
                   c, in_ready, out_valid, ea);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (ea !== 16'(next_out)) begin
          failures++;
          $display("FAIL bp_order: got %h want %h", ea, 16'(next_out));
        end
        if (cyc0 < 0) cyc0 = c;
        cycl = c;
        next_out++;
      end
      if (in_valid && in_ready) next_req++;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (next_out != 5 || cycl - cyc0 != 3) begin
      failures++;
      $display("FAIL bp_drain: got outputs=%0d span=%0d, want 4 and 3", next_out - 1, cycl - cyc0);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    logic c, v;
    logic [17:0] exp_r;
    int lat;
    bit ok;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    put_req(1'b1, 2'b01, 1'b0, 16'h0, 16'hFFFF, 16'h0002);
    @(negedge clk);
    put_req(1'b1, 2'b01, 1'b0, 16'h0, 16'h7FFF, 16'h0001);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b1 || ea !== 16'h0001 || carry !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: got v=%b ea=%h c=%b, want 1 0001 1", out_valid, ea, carry);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ea !== 16'h0 || carry !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: got v=%b ea=%h c=%b o=%b rdy=%b, want 0 0000 0 0 1",
               out_valid, ea, carry, ovf, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    put_req(1'b0, 2'b10, 1'b1, 16'h1000, 16'h0, 16'h0100);
    exp_r = model16_now();
    send_and_get(e, c, v, lat, ok);
    checks++;
    if (!ok || lat != 2 || {v, c, e} !== exp_r) begin
      failures++;
      $display("FAIL mid_after: got ok=%b lat=%0d res=%h, want lat=2 res=%h", ok, lat, {v, c, e}, exp_r);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_no_ghost: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [17:0] q[$];
    logic [17:0] hold, exp_r;
    bit have_hold;
    have_hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (have_hold) begin
        checks++;
        if (out_valid !== 1'b1 || {ovf, carry, ea} !== hold) begin
          failures++;
          $display("FAIL rnd_hold: got v=%b res=%h want v=1 res=%h", out_valid, {ovf, carry, ea}, hold);
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      put_req(1'($urandom), 2'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      #1;
      checks++;
      if (in_ready !== !(q.size() == 2 && !out_ready)) begin
        failures++;
        $display("FAIL rnd_in_ready: got %b with %0d in flight, out_ready=%b", in_ready, q.size(), out_ready);
      end
      if (q.size() == 0) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL rnd_empty_valid: got %b want 0", out_valid);
        end
      end
      have_hold = out_valid && !out_ready;
      hold      = {ovf, carry, ea};
      if (out_valid && out_ready) begin
        checks++;
        exp_r = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
        if ({ovf, carry, ea} !== exp_r) begin
          failures++;
          $display("FAIL rnd_result: got %h want %h", {ovf, carry, ea}, exp_r);
        end
      end
      if (in_valid && in_ready) q.push_back(model16_now());
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        checks++;
        exp_r = q.pop_front();
        if ({ovf, carry, ea} !== exp_r) begin
          failures++;
          $display("FAIL rnd_drain: got %h want %h", {ovf, carry, ea}, exp_r);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL rnd_lost: got %0d results missing, want 0", q.size());
    end
  endtask

  task automatic test_wide();
    longint e_l;
    bit c_m, v_m;
    logic [31:0] exp_e;
    logic exp_c, exp_v;
    bit ok;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) begin
        w_a1 = 1'b0; w_a2 = 2'b11; w_sc = 1'b0;
        w_pc = 32'h0001_0000; w_rg = '0; w_ir = 32'h001F_FFFF;
        exp_e = 32'h0000_FFFF; exp_c = 1'b1; exp_v = 1'b0;
      end else begin
        w_a1 = 1'($urandom); w_a2 = 2'($urandom); w_sc = 1'($urandom);
        w_pc = $urandom; w_rg = $urandom; w_ir = $urandom;
        ref_ea(32, fw32(w_a2), bit'(w_sc), w_a1 ? longint'(w_rg) : longint'(w_pc),
               longint'(w_ir), e_l, c_m, v_m);
        exp_e = 32'(e_l); exp_c = c_m; exp_v = v_m;
      end
      w_in_valid = 1'b1; w_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      w_in_valid = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (w_out_valid) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      checks++;
      if (!ok || w_ea !== exp_e || w_carry !== exp_c || w_ovf !== exp_v) begin
        failures++;
        $display("FAIL wide_%0d: got ok=%b ea=%h c=%b o=%b, want ea=%h c=%b o=%b",
                 i, ok, w_ea, w_carry, w_ovf, exp_e, exp_c, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_reset_mid();
    test_random();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
